// File: rtl/md_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Holds the MD-class op codes (also used by ID decode and the EX result mux)
// and the default latencies.
package md_sequencer_pkg;

  // MD-class op codes carried on EX_op
  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  // Default busy latencies
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // True for ops that occupy the unit for multiple cycles
  function automatic logic is_multicycle_op(input logic [2:0] op);
    logic r;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational HI/LO arithmetic: signed/unsigned 32x32->64 multiply and
// 32/32 divide. div0 flags a zero divisor so the sequencer can skip the commit.
module md_arith
  import md_sequencer_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div0
);

  logic signed [63:0] sprod_s;
  logic        [63:0] uprod_s;
  logic               ovf_s;
  logic               bzero_s;
  logic        [31:0] b_safe_s;
  logic signed [31:0] squot_s;
  logic signed [31:0] srem_s;
  logic        [31:0] uquot_s;
  logic        [31:0] urem_s;

  // Raw products and quotients; the divisor is forced to 1 for the zero and
  // INT_MIN/-1 cases so the divider never sees an undefined operation.
  always_comb begin
    sprod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    uprod_s  = {32'd0, a} * {32'd0, b};
    bzero_s  = (b == 32'd0);
    ovf_s    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    b_safe_s = (bzero_s || ovf_s) ? 32'd1 : b;
    squot_s  = $signed(a) / $signed(b_safe_s);
    srem_s   = $signed(a) % $signed(b_safe_s);
    uquot_s  = a / b_safe_s;
    urem_s   = a % b_safe_s;
  end

  // Select HI/LO per op; non-arithmetic ops produce zeros.
  always_comb begin
    hi   = 32'd0;
    lo   = 32'd0;
    div0 = 1'b0;
    case (op)
      MD_MULT: begin
        hi = sprod_s[63:32];
        lo = sprod_s[31:0];
      end
      MD_MULTU: begin
        hi = uprod_s[63:32];
        lo = uprod_s[31:0];
      end
      MD_DIV: begin
        if (bzero_s) begin
          div0 = 1'b1;
        end else if (ovf_s) begin
          hi = 32'd0;
          lo = 32'h8000_0000;
        end else begin
          hi = srem_s;
          lo = squot_s;
        end
      end
      MD_DIVU: begin
        if (bzero_s) begin
          div0 = 1'b1;
        end else begin
          hi = urem_s;
          lo = uquot_s;
        end
      end
      default: begin
        hi   = 32'd0;
        lo   = 32'd0;
        div0 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// HI/LO multiply/divide sequencer. Accepts MD-class ops from EX, holds the
// result in pending registers for the modelled latency, then commits to the
// architectural HI/LO. Drives the ID-stage stall while the unit is occupied.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_valid,
  input  logic [2:0]  EX_op,
  input  logic [31:0] EX_A,
  input  logic [31:0] EX_B,
  input  logic        cancel,
  input  logic        ID_MD,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic               busy_r, busy_nxt_s;
  logic [31:0]        hi_r, hi_nxt_s;
  logic [31:0]        lo_r, lo_nxt_s;
  logic [31:0]        pend_hi_r, pend_hi_nxt_s;
  logic [31:0]        pend_lo_r, pend_lo_nxt_s;
  logic               pend_div0_r, pend_div0_nxt_s;

  logic               accept_s;
  logic [31:0]        arith_hi_s;
  logic [31:0]        arith_lo_s;
  logic               arith_div0_s;

  md_arith u_arith (
    .op   (EX_op),
    .a    (EX_A),
    .b    (EX_B),
    .hi   (arith_hi_s),
    .lo   (arith_lo_s),
    .div0 (arith_div0_s)
  );

  assign accept_s = EX_valid & ~cancel & (state_r == ST_IDLE);

  // Next-state logic: accept/launch from IDLE, count down and commit when busy.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    busy_nxt_s      = busy_r;
    hi_nxt_s        = hi_r;
    lo_nxt_s        = lo_r;
    pend_hi_nxt_s   = pend_hi_r;
    pend_lo_nxt_s   = pend_lo_r;
    pend_div0_nxt_s = pend_div0_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (EX_op)
            MD_MULT, MD_MULTU: begin
              state_nxt_s     = ST_MUL;
              cnt_nxt_s       = CNT_W'(MULT_CYCLES - 1);
              busy_nxt_s      = 1'b1;
              pend_hi_nxt_s   = arith_hi_s;
              pend_lo_nxt_s   = arith_lo_s;
              pend_div0_nxt_s = 1'b0;
            end
            MD_DIV, MD_DIVU: begin
              state_nxt_s     = ST_DIV;
              cnt_nxt_s       = CNT_W'(DIV_CYCLES - 1);
              busy_nxt_s      = 1'b1;
              pend_hi_nxt_s   = arith_hi_s;
              pend_lo_nxt_s   = arith_lo_s;
              pend_div0_nxt_s = arith_div0_s;
            end
            MD_MTHI: begin
              hi_nxt_s = EX_A;
            end
            MD_MTLO: begin
              lo_nxt_s = EX_A;
            end
            default: begin
              state_nxt_s = ST_IDLE;
            end
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        // EX_valid is ignored here; the stall keeps new MD ops out of EX.
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nxt_s = ST_IDLE;
          busy_nxt_s  = 1'b0;
          if (!pend_div0_r) begin
            hi_nxt_s = pend_hi_r;
            lo_nxt_s = pend_lo_r;
          end else begin
            hi_nxt_s = hi_r;
            lo_nxt_s = lo_r;
          end
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, counter, pending and architectural HI/LO registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      busy_r      <= 1'b0;
      hi_r        <= 32'd0;
      lo_r        <= 32'd0;
      pend_hi_r   <= 32'd0;
      pend_lo_r   <= 32'd0;
      pend_div0_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      busy_r      <= busy_nxt_s;
      hi_r        <= hi_nxt_s;
      lo_r        <= lo_nxt_s;
      pend_hi_r   <= pend_hi_nxt_s;
      pend_lo_r   <= pend_lo_nxt_s;
      pend_div0_r <= pend_div0_nxt_s;
    end
  end

  // Stall must rise in the accept cycle of a multi-cycle op, so it looks at EX
  // combinationally as well as at the registered busy flag.
  assign md_stall = ID_MD & (busy_r | (EX_valid & ~cancel & is_multicycle_op(EX_op)));

  assign busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed testbench for md_sequencer. Inputs are driven at the falling edge
// and outputs sampled at the falling edge (or 1ns after) away from the rising edge.
module tb_md_sequencer;
  import md_sequencer_pkg::*;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic        cancel;
  logic        id_md;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests_run;
  int tests_failed;

  md_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .EX_valid (ex_valid),
    .EX_op    (ex_op),
    .EX_A     (ex_a),
    .EX_B     (ex_b),
    .cancel   (cancel),
    .ID_MD    (id_md),
    .busy     (busy),
    .md_stall (md_stall),
    .HI       (hi),
    .LO       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one op in EX for one cycle; returns at the negedge after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    ex_op    = op;
    ex_a     = a;
    ex_b     = b;
    ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    ex_op    = MD_NONE;
  endtask

  // Count negedges with busy high; bounded so a stuck unit cannot hang the run.
  task automatic busy_wait(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || md_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: busy=%b stall=%b HI=%h LO=%h, want 0/0/0/0", busy, md_stall, hi, lo);
    end
    reset = 1'b1;
    @(negedge clk);
    issue(MD_MTHI, 32'h55, 32'd0);
    issue(MD_MTLO, 32'h66, 32'd0);
    tests_run++;
    if (hi !== 32'h55 || lo !== 32'h66) begin
      tests_failed++;
      $display("FAIL reset_preload: HI=%h LO=%h, want 00000055/00000066", hi, lo);
    end
    issue(MD_DIV, 32'd7, 32'd2);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_div: busy=%b HI=%h LO=%h, want 0/0/0", busy, hi, lo);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    busy_wait(n);
    tests_run++;
    if (n !== 0 || hi !== 32'd0 || lo !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_release: busy_cycles=%0d HI=%h LO=%h, want 0/0/0", n, hi, lo);
    end
  endtask

  task automatic test_mult();
    int n;
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    tests_run++;
    if (busy !== 1'b1 || hi !== 32'd0) begin
      tests_failed++;
      $display("FAIL mult_inflight: busy=%b HI=%h, want 1/00000000", busy, hi);
    end
    busy_wait(n);
    tests_run++;
    if (n !== 5 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      tests_failed++;
      $display("FAIL mult: cycles=%0d HI=%h LO=%h, want 5/ffffffff/fffffffa", n, hi, lo);
    end
    issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
    busy_wait(n);
    tests_run++;
    if (n !== 5 || hi !== 32'h0000_0002 || lo !== 32'hFFFF_FFFA) begin
      tests_failed++;
      $display("FAIL multu: cycles=%0d HI=%h LO=%h, want 5/00000002/fffffffa", n, hi, lo);
    end
  endtask

  task automatic test_div();
    int n;
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    busy_wait(n);
    tests_run++;
    if (n !== 10 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      tests_failed++;
      $display("FAIL div_neg: cycles=%0d HI=%h LO=%h, want 10/ffffffff/fffffffd", n, hi, lo);
    end
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    busy_wait(n);
    tests_run++;
    if (n !== 10 || hi !== 32'd0 || lo !== 32'h8000_0000) begin
      tests_failed++;
      $display("FAIL div_ovf: cycles=%0d HI=%h LO=%h, want 10/00000000/80000000", n, hi, lo);
    end
    issue(MD_DIVU, 32'hFFFF_FFFF, 32'd16);
    busy_wait(n);
    tests_run++;
    if (n !== 10 || hi !== 32'h0000_000F || lo !== 32'h0FFF_FFFF) begin
      tests_failed++;
      $display("FAIL divu: cycles=%0d HI=%h LO=%h, want 10/0000000f/0fffffff", n, hi, lo);
    end
    issue(MD_DIVU, 32'd5, 32'd0);
    busy_wait(n);
    tests_run++;
    if (n !== 10 || hi !== 32'h0000_000F || lo !== 32'h0FFF_FFFF) begin
      tests_failed++;
      $display("FAIL divu_zero: cycles=%0d HI=%h LO=%h, want 10/0000000f/0fffffff", n, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int bn;
    int sn;
    int n;
    id_md    = 1'b1;
    ex_op    = MD_MULT;
    ex_a     = 32'd3;
    ex_b     = 32'd4;
    ex_valid = 1'b1;
    #1;
    tests_run++;
    if (md_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_accept_stall: md_stall=%b, want 1", md_stall);
    end
    @(negedge clk);
    ex_valid = 1'b0;
    ex_op    = MD_NONE;
    bn = 0;
    sn = 0;
    while (busy === 1'b1 && bn < 40) begin
      bn++;
      #1;
      if (md_stall === 1'b1) sn++;
      @(negedge clk);
    end
    #1;
    tests_run++;
    if (bn !== 5 || sn !== 5 || md_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_stall_window: busy=%0d stall=%0d stall_after=%b, want 5/5/0", bn, sn, md_stall);
    end
    tests_run++;
    if (hi !== 32'd0 || lo !== 32'd12) begin
      tests_failed++;
      $display("FAIL b2b_first: HI=%h LO=%h, want 00000000/0000000c", hi, lo);
    end
    ex_op    = MD_DIVU;
    ex_a     = 32'd100;
    ex_b     = 32'd7;
    ex_valid = 1'b1;
    #1;
    tests_run++;
    if (md_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_second_stall: md_stall=%b, want 1", md_stall);
    end
    @(negedge clk);
    ex_valid = 1'b0;
    ex_op    = MD_NONE;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_second_accept: busy=%b, want 1", busy);
    end
    busy_wait(n);
    tests_run++;
    if (n !== 10 || hi !== 32'd2 || lo !== 32'd14) begin
      tests_failed++;
      $display("FAIL b2b_second: cycles=%0d HI=%h LO=%h, want 10/00000002/0000000e", n, hi, lo);
    end
    id_md = 1'b0;
  endtask

  task automatic test_cancel();
    int n;
    id_md    = 1'b1;
    cancel   = 1'b1;
    ex_op    = MD_MULT;
    ex_a     = 32'd7;
    ex_b     = 32'd7;
    ex_valid = 1'b1;
    #1;
    tests_run++;
    if (md_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL cancel_stall: md_stall=%b, want 0", md_stall);
    end
    @(negedge clk);
    ex_valid = 1'b0;
    ex_op    = MD_NONE;
    cancel   = 1'b0;
    id_md    = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || hi !== 32'd2 || lo !== 32'd14) begin
      tests_failed++;
      $display("FAIL cancel_mult: busy=%b HI=%h LO=%h, want 0/00000002/0000000e", busy, hi, lo);
    end
    issue(MD_DIV, 32'd101, 32'hFFFF_FFF9);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      cancel = (n == 3);
      @(negedge clk);
    end
    cancel = 1'b0;
    tests_run++;
    if (n !== 10 || hi !== 32'd3 || lo !== 32'hFFFF_FFF2) begin
      tests_failed++;
      $display("FAIL cancel_inflight_div: cycles=%0d HI=%h LO=%h, want 10/00000003/fffffff2", n, hi, lo);
    end
  endtask

  task automatic test_mthi_mtlo();
    id_md    = 1'b1;
    ex_op    = MD_MTHI;
    ex_a     = 32'h1234;
    ex_b     = 32'd0;
    ex_valid = 1'b1;
    #1;
    tests_run++;
    if (md_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL mthi_stall: md_stall=%b, want 0", md_stall);
    end
    @(negedge clk);
    ex_valid = 1'b0;
    ex_op    = MD_NONE;
    id_md    = 1'b0;
    tests_run++;
    if (hi !== 32'h1234 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL mthi: HI=%h busy=%b, want 00001234/0", hi, busy);
    end
    cancel = 1'b1;
    issue(MD_MTLO, 32'hBEEF, 32'd0);
    cancel = 1'b0;
    tests_run++;
    if (lo !== 32'hFFFF_FFF2) begin
      tests_failed++;
      $display("FAIL mtlo_cancel: LO=%h, want fffffff2", lo);
    end
    issue(MD_MTLO, 32'hBEEF, 32'd0);
    tests_run++;
    if (lo !== 32'hBEEF || hi !== 32'h1234) begin
      tests_failed++;
      $display("FAIL mtlo: HI=%h LO=%h, want 00001234/0000beef", hi, lo);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    ex_valid     = 1'b0;
    ex_op        = MD_NONE;
    ex_a         = 32'd0;
    ex_b         = 32'd0;
    cancel       = 1'b0;
    id_md        = 1'b0;
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_back_to_back();
    test_cancel();
    test_mthi_mtlo();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
